// File: rtl/nubus_master_fsm_if.sv
// Signal bundle between the NuBus master sequencer, the local requester
// and the bus driver that turns the strobes into START*/RQST*/ACK*/TM*.
interface nubus_master_fsm_if;
    logic [3:0] nub_idn;
    logic [3:0] nub_arbn_i;
    logic       nub_rqstn_i;
    logic       nub_startn_i;
    logic       nub_ackn_i;
    logic [1:0] nub_tmn_i;
    logic       loc_req;
    logic       loc_lock;
    logic [1:0] loc_tm;
    logic       loc_done;
    logic       loc_err;
    logic       mst_arbcyn;
    logic       mst_adrcyn;
    logic       mst_dtacyn;
    logic       mst_ownern;
    logic       mst_lockedn;
    logic       mst_tm1n;
    logic       mst_tm0n;
    logic       mst_timeout;

    modport master (
        input  nub_idn, nub_arbn_i, nub_rqstn_i, nub_startn_i, nub_ackn_i, nub_tmn_i,
        input  loc_req, loc_lock, loc_tm,
        output loc_done, loc_err,
        output mst_arbcyn, mst_adrcyn, mst_dtacyn, mst_ownern, mst_lockedn,
        output mst_tm1n, mst_tm0n, mst_timeout
    );

    modport slave (
        output nub_idn, nub_arbn_i, nub_rqstn_i, nub_startn_i, nub_ackn_i, nub_tmn_i,
        output loc_req, loc_lock, loc_tm,
        input  loc_done, loc_err,
        input  mst_arbcyn, mst_adrcyn, mst_dtacyn, mst_ownern, mst_lockedn,
        input  mst_tm1n, mst_tm0n, mst_timeout
    );
endinterface

// File: rtl/nubus_master_fsm.sv
// NuBus master sequencer: fair arbitration, bus-idle wait, address/data cycles,
// locked sequences and NULL-ATTN release, all with registered active-low strobes.
module nubus_master_fsm #(
    parameter int ARB_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic               nub_clk,
    input  logic               nub_reset,
    inout  wire  [3:0]         nub_arbn_o,
    nubus_master_fsm_if.master bus
);

    typedef enum logic [2:0] {IDLE, ARB, WAIT_BUS, ADDR, DATA, ATTN} state_t;

    state_t     state;
    state_t     nxt;
    logic       lock_q;
    logic       busy_q;
    logic       lost_q;
    logic       tail_q;
    logic [7:0] arb_cnt;
    logic [7:0] to_cnt;
    logic       nxt_tail;
    logic       done_now;
    logic       err_now;
    logic       tmo_now;
    logic       arb_term;
    logic       to_term;
    logic       arbitrating;

    assign arb_term    = (arb_cnt == 8'(ARB_CYCLES - 1));
    assign to_term     = (to_cnt == 8'(TIMEOUT_CYCLES - 1));
    assign arbitrating = (state == ARB) && !lost_q;

    // Open-collector ARB*: pull low where our (active-high) ID bit is 1.
    for (genvar k = 0; k < 4; k++) begin : g_arb
        assign nub_arbn_o[k] = (arbitrating && !bus.nub_idn[k]) ? 1'b0 : 1'bz;
    end

    always_comb begin
        nxt      = state;
        nxt_tail = 1'b0;
        done_now = 1'b0;
        err_now  = 1'b0;
        tmo_now  = 1'b0;
        case (state)
            IDLE: if (bus.loc_req && bus.nub_rqstn_i) nxt = ARB;
            ARB: begin
                if (!bus.loc_req)
                    nxt = IDLE;
                else if (!lost_q && arb_term && (bus.nub_arbn_i == bus.nub_idn))
                    nxt = WAIT_BUS;
            end
            WAIT_BUS: begin
                if (!bus.loc_req)
                    nxt = IDLE;
                else if (!busy_q && bus.nub_startn_i)
                    nxt = ADDR;
            end
            ADDR: nxt = DATA;
            DATA: begin
                // The tail clock lets the requester show its follow-up after loc_done.
                if (tail_q) begin
                    nxt = (bus.loc_req && bus.loc_lock) ? ADDR : ATTN;
                end else if (!bus.nub_ackn_i || to_term) begin
                    done_now = 1'b1;
                    err_now  = bus.nub_ackn_i ? 1'b1 : (bus.nub_tmn_i != 2'b11);
                    tmo_now  = bus.nub_ackn_i;
                    if (lock_q) nxt_tail = 1'b1;
                    else        nxt = IDLE;
                end
            end
            ATTN: nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge nub_clk or posedge nub_reset) begin
        if (nub_reset) begin
            state           <= IDLE;
            lock_q          <= 1'b0;
            busy_q          <= 1'b0;
            lost_q          <= 1'b0;
            tail_q          <= 1'b0;
            arb_cnt         <= '0;
            to_cnt          <= '0;
            bus.loc_done    <= 1'b0;
            bus.loc_err     <= 1'b0;
            bus.mst_timeout <= 1'b0;
            bus.mst_arbcyn  <= 1'b1;
            bus.mst_adrcyn  <= 1'b1;
            bus.mst_dtacyn  <= 1'b1;
            bus.mst_ownern  <= 1'b1;
            bus.mst_lockedn <= 1'b1;
            bus.mst_tm1n    <= 1'b1;
            bus.mst_tm0n    <= 1'b1;
        end else begin
            state           <= nxt;
            tail_q          <= nxt_tail;
            bus.loc_done    <= done_now;
            bus.loc_err     <= err_now;
            bus.mst_timeout <= tmo_now;

            if (!bus.nub_ackn_i)
                busy_q <= 1'b0;
            else if (!bus.nub_startn_i && bus.mst_ownern)
                busy_q <= 1'b1;

            case (state)
                IDLE: begin
                    lost_q  <= 1'b0;
                    arb_cnt <= '0;
                    if (nxt == ARB) lock_q <= bus.loc_lock;
                end
                ARB: begin
                    // A loser waits for the winner's START* before competing again.
                    if (lost_q) begin
                        if (!bus.nub_startn_i) begin
                            lost_q  <= 1'b0;
                            arb_cnt <= '0;
                        end
                    end else if (arb_term) begin
                        lost_q <= (bus.nub_arbn_i != bus.nub_idn);
                    end else begin
                        arb_cnt <= arb_cnt + 8'd1;
                    end
                end
                ADDR: to_cnt <= '0;
                DATA: if (!tail_q) to_cnt <= to_cnt + 8'd1;
                ATTN: lock_q <= 1'b0;
                default: ;
            endcase

            bus.mst_arbcyn  <= !((nxt inside {ARB, WAIT_BUS, ADDR, ATTN}) || (nxt == DATA && lock_q));
            bus.mst_adrcyn  <= (nxt != ADDR);
            bus.mst_dtacyn  <= !(nxt == DATA && !nxt_tail);
            bus.mst_ownern  <= !(nxt inside {ADDR, DATA, ATTN});
            bus.mst_lockedn <= !((nxt inside {ADDR, DATA}) && lock_q);
            {bus.mst_tm1n, bus.mst_tm0n} <= (nxt == ADDR) ? ~bus.loc_tm : 2'b11;
        end
    end

endmodule

// File: tb/tb_nubus_master_fsm.sv
// Scoreboard bench for nubus_master_fsm: requester and slave stimulus,
// expected completions queued at request time and retired on loc_done.
module tb_nubus_master_fsm;

    localparam int P_IDLE = 0, P_ARB = 1, P_ADDR = 2, P_DATA = 3, P_ATTN = 4, P_HOLD = 5;

    typedef struct {
        logic err;
        logic tmo;
        int   due;
        int   dlat;
    } sb_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    int         cyc = 0;
    tri1  [3:0] arb_bus;
    logic       force_arb = 1'b0;
    logic [3:0] ext_arb = 4'hF;
    logic       ack_en = 1'b0;
    logic       ext_ack = 1'b0;

    int n_vec  = 0;
    int n_miss = 0;
    sb_t sb[$];

    logic [31:0] raw, col;
    int          lastc, prevph, gap, done_cnt, tmo_cnt, own_seen, lock_cnt, data_cyc;
    logic [3:0]  arb_and;
    logic [1:0]  tm_seen;

    nubus_master_fsm_if bus ();

    assign bus.nub_arbn_i = force_arb ? ext_arb : arb_bus;
    assign bus.nub_ackn_i = !((ack_en && !bus.mst_dtacyn) || ext_ack);

    nubus_master_fsm #(.ARB_CYCLES(2), .TIMEOUT_CYCLES(255)) dut (
        .nub_clk    (clk),
        .nub_reset  (rst),
        .nub_arbn_o (arb_bus),
        .bus        (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic int phase();
        if (bus.mst_ownern) return bus.mst_arbcyn ? P_IDLE : P_ARB;
        if (!bus.mst_adrcyn) return P_ADDR;
        if (!bus.mst_dtacyn) return P_DATA;
        if (!bus.mst_lockedn) return P_HOLD;
        return P_ATTN;
    endfunction

    task automatic clr_trace();
        raw = '0; col = '0; lastc = -1; prevph = P_IDLE; gap = 0; done_cnt = 0;
        tmo_cnt = 0; own_seen = 0; lock_cnt = 0; data_cyc = -1; arb_and = 4'hF; tm_seen = 2'b00;
    endtask

    task automatic step();
        int ph;
        @(negedge clk);
        ph = phase();
        if (ph != P_IDLE) raw = {raw[27:0], 4'(ph)};
        if (ph != P_IDLE && ph != P_HOLD && ph != lastc) begin
            col   = {col[27:0], 4'(ph)};
            lastc = ph;
        end
        if (ph == P_DATA && prevph != P_DATA) data_cyc = cyc;
        if (ph == P_ARB) arb_and = arb_and & arb_bus;
        if (ph == P_ADDR) tm_seen = {bus.mst_tm1n, bus.mst_tm0n};
        if (!bus.mst_ownern && bus.mst_arbcyn) gap++;
        if (!bus.mst_ownern) own_seen++;
        if (!bus.mst_lockedn) lock_cnt++;
        if (bus.loc_done) done_cnt++;
        if (bus.mst_timeout) tmo_cnt++;
        prevph = ph;
    endtask

    task automatic push(input logic err, input logic tmo, input int due, input int dlat);
        sb_t e;
        e.err = err; e.tmo = tmo; e.due = due; e.dlat = dlat;
        sb.push_back(e);
    endtask

    task automatic wait_done(input string tag, input int bound);
        sb_t e;
        int  k;
        for (k = 0; k < bound; k++) begin
            step();
            if (bus.loc_done) break;
        end
        if (k == bound) begin
            check({tag, "_done_bound"}, 32'd0, 32'd1);
        end else if (sb.size() == 0) begin
            check({tag, "_unexpected_done"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check({tag, "_err"}, 32'(bus.loc_err), 32'(e.err));
            check({tag, "_timeout"}, 32'(bus.mst_timeout), 32'(e.tmo));
            if (e.due >= 0) check({tag, "_done_cycle"}, 32'(cyc), 32'(e.due));
            if (e.dlat >= 0) check({tag, "_data_latency"}, 32'(cyc - data_cyc), 32'(e.dlat));
        end
    endtask

    task automatic wait_phase(input string tag, input int want, input int bound);
        int k;
        for (k = 0; k < bound; k++) begin
            step();
            if (phase() == want) break;
        end
        if (k == bound) check({tag, "_phase_bound"}, 32'd0, 32'd1);
    endtask

    initial begin
        int c0;
        bus.nub_idn = ~4'hE;
        bus.nub_rqstn_i = 1'b1;
        bus.nub_startn_i = 1'b1;
        bus.nub_tmn_i = 2'b11;
        bus.loc_req = 1'b0;
        bus.loc_lock = 1'b0;
        bus.loc_tm = 2'b00;
        clr_trace();

        // reset state
        repeat (3) step();
        check("rst_strobes", 32'({bus.mst_arbcyn, bus.mst_adrcyn, bus.mst_dtacyn, bus.mst_ownern,
                                  bus.mst_lockedn, bus.mst_tm1n, bus.mst_tm0n}), 32'h7F);
        check("rst_arb_z", 32'(arb_bus), 32'hF);
        check("rst_outs", 32'({bus.mst_timeout, bus.loc_done, bus.loc_err}), 32'h0);
        rst = 1'b0;
        step();

        // uncontended transaction, ID 0xE, ACK on first DATA clock
        clr_trace();
        ack_en = 1'b1;
        bus.loc_tm = 2'b01;
        bus.loc_req = 1'b1;
        c0 = cyc;
        push(1'b0, 1'b0, c0 + 6, 1);
        wait_done("t1", 20);
        bus.loc_req = 1'b0;
        repeat (2) step();
        check("t1_trace", raw, 32'h11123);
        check("t1_arb_drive", 32'(arb_and), 32'h1);
        check("t1_tm", 32'(tm_seen), 32'h2);
        check("t1_unlocked_arbcyn", 32'(gap), 32'd1);
        check("t1_done_count", 32'(done_cnt), 32'd1);

        // slave returns non-zero TM on ACK
        clr_trace();
        bus.nub_tmn_i = 2'b10;
        bus.loc_req = 1'b1;
        push(1'b1, 1'b0, cyc + 6, 1);
        wait_done("t2", 20);
        bus.loc_req = 1'b0;
        bus.nub_tmn_i = 2'b11;
        repeat (2) step();

        // RQST* low from other masters holds off arbitration
        clr_trace();
        bus.nub_rqstn_i = 1'b0;
        bus.loc_req = 1'b1;
        repeat (5) step();
        check("t3_held_idle", raw, 32'h0);
        bus.nub_rqstn_i = 1'b1;
        c0 = cyc;
        push(1'b0, 1'b0, c0 + 6, 1);
        step();
        check("t3_arb_next", 32'(phase()), 32'(P_ARB));
        wait_done("t3", 20);
        bus.loc_req = 1'b0;
        repeat (2) step();

        // contention: DUT ID 0x3 loses to 0xC, wins after next START*
        clr_trace();
        bus.nub_idn = ~4'h3;
        force_arb = 1'b1;
        ext_arb = ~4'hC;
        bus.loc_req = 1'b1;
        repeat (10) step();
        check("t4_lost_in_arb", 32'(phase()), 32'(P_ARB));
        check("t4_no_owner", 32'(own_seen), 32'd0);
        bus.nub_startn_i = 1'b0;
        ext_arb = ~4'h3;
        step();
        bus.nub_startn_i = 1'b1;
        step();
        ext_ack = 1'b1;
        step();
        ext_ack = 1'b0;
        push(1'b0, 1'b0, -1, 1);
        wait_done("t4", 20);
        bus.loc_req = 1'b0;
        force_arb = 1'b0;
        ext_arb = 4'hF;
        bus.nub_idn = ~4'hE;
        repeat (2) step();
        check("t4_phases", col, 32'h123);

        // no ACK: timeout 255 clocks after entering DATA
        clr_trace();
        ack_en = 1'b0;
        bus.loc_req = 1'b1;
        push(1'b1, 1'b1, -1, 255);
        wait_done("t5", 300);
        bus.loc_req = 1'b0;
        repeat (2) step();
        check("t5_tmo_pulse", 32'(tmo_cnt), 32'd1);

        // locked pair: single arbitration, ATTN at the end
        clr_trace();
        ack_en = 1'b1;
        bus.loc_lock = 1'b1;
        bus.loc_tm = 2'b11;
        bus.loc_req = 1'b1;
        push(1'b0, 1'b0, -1, 1);
        push(1'b0, 1'b0, -1, 1);
        wait_done("t6a", 20);
        bus.loc_tm = 2'b00;
        wait_done("t6b", 20);
        bus.loc_req = 1'b0;
        bus.loc_lock = 1'b0;
        repeat (4) step();
        check("t6_phases", col, 32'h123234);
        check("t6_arbcyn_held", 32'(gap), 32'd0);
        check("t6_locked_seen", 32'(lock_cnt != 0), 32'd1);
        check("t6_tm_second", 32'(tm_seen), 32'h3);
        check("t6_idle_after", 32'(phase()), 32'(P_IDLE));

        // request dropped during arbitration: abort, no bus cycle
        clr_trace();
        bus.loc_req = 1'b1;
        repeat (2) step();
        bus.loc_req = 1'b0;
        repeat (4) step();
        check("t7_no_owner", 32'(own_seen), 32'd0);
        check("t7_no_done", 32'(done_cnt), 32'd0);
        check("t7_idle", 32'(phase()), 32'(P_IDLE));

        // asynchronous reset mid-DATA
        clr_trace();
        ack_en = 1'b0;
        bus.loc_req = 1'b1;
        wait_phase("t8", P_DATA, 10);
        #2 rst = 1'b1;
        #1;
        check("t8_strobes_released", 32'({bus.mst_arbcyn, bus.mst_adrcyn, bus.mst_dtacyn,
               bus.mst_ownern, bus.mst_lockedn, bus.mst_tm1n, bus.mst_tm0n}), 32'h7F);
        check("t8_arb_z", 32'(arb_bus), 32'hF);
        step();
        rst = 1'b0;
        bus.loc_req = 1'b0;
        repeat (3) step();
        check("t8_no_done", 32'(done_cnt), 32'd0);

        // normal operation resumes after reset
        clr_trace();
        ack_en = 1'b1;
        bus.loc_tm = 2'b10;
        bus.loc_req = 1'b1;
        push(1'b0, 1'b0, cyc + 6, 1);
        wait_done("t9", 20);
        bus.loc_req = 1'b0;
        repeat (2) step();
        check("t9_trace", raw, 32'h11123);
        check("t9_tm", 32'(tm_seen), 32'h1);

        // ACK and timeout on the same clock: ACK wins
        clr_trace();
        ack_en = 1'b0;
        bus.loc_req = 1'b1;
        push(1'b0, 1'b0, -1, 255);
        wait_phase("t10", P_DATA, 10);
        repeat (254) step();
        ext_ack = 1'b1;
        wait_done("t10", 5);
        ext_ack = 1'b0;
        bus.loc_req = 1'b0;
        repeat (2) step();
        check("t10_no_tmo", 32'(tmo_cnt), 32'd0);
        check("t10_sb_empty", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/nubus_master_fsm.md
# nubus_master_fsm

Master-side sequencer for the NuBus interface. It accepts local transaction requests, runs distributed arbitration on ARB[3:0], and waits for the bus to go idle. It then steps through address, data and optional attention cycles. Its outputs are the active-low state strobes (arbcy/adrcy/dtacy/owner/locked/tm/timeout) consumed by the NuBus bus driver, which turns them into START*, RQST*, ACK* and TM*.

## Interface
- `ARB_CYCLES`, default 2: clocks of arbitration settling before the win/lose compare.
- `TIMEOUT_CYCLES`, default 255: clocks in DATA without ACK* before a forced timeout (8-bit counter).
- `nub_clk` in 1: NuBus clock. All state updates happen on the rising edge.
- `nub_reset` in 1: asynchronous, active-high reset.
- `nub_idn` in 4: slot ID, active low, static.
- `nub_arbn_i` in 4: sampled ARB* lines.
- `nub_arbn_o` in/out 4: ARB* drive, open-collector. Each bit drives 0 where the ID bit is 1, Z otherwise, and only while arbitrating.
- `nub_rqstn_i` in 1: sampled RQST*.
- `nub_startn_i` in 1: sampled START*.
- `nub_ackn_i` in 1: sampled ACK*.
- `loc_req` in 1: local transaction request, level. Held until `loc_done`.
- `loc_lock` in 1: request belongs to a locked sequence.
- `loc_tm` in 2: TM1/TM0 for the address cycle, active high.
- `loc_done` out 1: one-clock pulse when a transaction ends (ACK or timeout).
- `loc_err` out 1: valid with `loc_done`. Set on timeout or when the slave returned a non-zero TM on ACK*.
- `mst_arbcyn`, `mst_adrcyn`, `mst_dtacyn`, `mst_ownern`, `mst_lockedn`, `mst_tm1n`, `mst_tm0n` out 1 each: strobes to the bus driver, active low.
- `mst_timeout` out 1: active high, one clock, to the bus driver.

## Operation
States: IDLE, ARB, WAIT_BUS, ADDR, DATA, ATTN. All strobe outputs are registered.

Output encoding per state (0 = asserted for the `n` outputs):
- IDLE: all `n` strobes = 1.
- ARB: arbcyn=0.
- WAIT_BUS: arbcyn=0.
- ADDR: arbcyn=0, adrcyn=0, ownern=0, dtacyn=1, tm1n/tm0n = ~loc_tm.
- DATA: arbcyn = ~lock_q, adrcyn=1, dtacyn=0, ownern=0.
- ATTN: arbcyn=0, adrcyn=1, dtacyn=1, ownern=0, lockedn=1. With these strobes the driver issues NULL-ATTN.
- lockedn = ~lock_q in ADDR and DATA, 1 elsewhere.

Bus-busy tracker:
- Set on `nub_startn_i`=0 while not owner.
- Cleared on `nub_ackn_i`=0.
- Reset value 0.

State transitions:
- IDLE→ARB: `loc_req`=1 and `nub_rqstn_i`=1. RQST* already low from others holds the block off (fairness). `lock_q` latches `loc_lock`. Arb counter cleared.
- ARB: drive `nub_arbn_o` and count ARB_CYCLES clocks.
  - At terminal count, if `nub_arbn_i` equals `nub_idn` → win → WAIT_BUS.
  - Otherwise lose: stay in ARB and restart the counter on the next observed START* low.
- WAIT_BUS→ADDR: first clock with busy=0 and `nub_startn_i`=1.
- ADDR→DATA: always, after 1 clock.
- DATA: timeout counter increments each clock.
  - On `nub_ackn_i`=0: pulse `loc_done`; `loc_err` = (`nub_arbn_i` unused; TM sampled) error if the slave TM ≠ 00.
  - On counter = TIMEOUT_CYCLES: assert `mst_timeout` and `loc_done`, with `loc_err`=1.
  - Next state on completion:
    - not `lock_q` → IDLE.
    - `lock_q` with `loc_req`=1 and `loc_lock`=1 on the following clock → ADDR (bus retained, no re-arbitration).
    - `lock_q` otherwise → ATTN.
- ATTN→IDLE: after 1 clock. `lock_q` cleared.

## Timing
- Reset (asynchronous):
  - state=IDLE, all `n` outputs=1, `nub_arbn_o`=Z, `mst_timeout`=0, `loc_done`=0, `loc_err`=0, counters=0, busy=0.
- Minimum uncontended transaction: IDLE→ARB (1) + ARB (ARB_CYCLES) + WAIT_BUS (1) + ADDR (1) + DATA (≥1). `loc_done` appears the clock after ACK* is sampled, i.e. 6 clocks from `loc_req` with ACK on the first DATA clock.
- `loc_req` dropped before ADDR: abort to IDLE next clock with no bus cycle and no `loc_done`. Dropped after ADDR: ignored.
- ACK* and timeout on the same clock: ACK wins, `loc_err` reflects TM only.
- Reset mid-DATA: outputs release immediately (asynchronous). No `loc_done`.

## Test plan
- Uncontended write, ID=0xE, ACK on first DATA clock → strobe sequence ARB×3, ADDR×1, DATA×1; `loc_done`=1, `loc_err`=0 at clock 6.
- Two masters, IDs 0x3 and 0xC, with `nub_arbn_i` forced to ~0xC while the DUT has ID 0x3 → DUT stays in ARB and never asserts ownern; it wins after the next START* and arbitration with ~0x3.
- No ACK → `mst_timeout` pulses exactly 255 clocks after entering DATA; `loc_done`=1, `loc_err`=1.
- Locked pair (2 requests with `loc_lock`=1, then drop) → ADDR, DATA, ADDR, DATA, ATTN, with arbcyn=0 throughout and a single arbitration.
- `nub_rqstn_i`=0 held at request time → the block stays in IDLE until it releases, then enters ARB next clock.
- `nub_reset` asserted mid-DATA → all `n` outputs=1 and `nub_arbn_o`=Z within the same clock. Normal operation resumes after release.
